// File: rtl/aes_inv_core.sv
// aes_inv_core: AES-256 inverse cipher, one round per clock, round keys requested by index over rk_idx_o/rk_i.
// Latency: done_o rises on the 16th edge counting the start-accept edge; the next start is accepted in the done cycle.
// Backpressure: hold_i freezes every register; start_i is sampled only when idle and not held.

// Inverse S-box: inverse affine map followed by the multiplicative inverse in GF(2^8) mod 0x11B.
module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] p, input logic [7:0] q);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = p;
        for (int i = 0; i < 8; i++) begin
            if (q[i]) acc = acc ^ sh;
            sh = xt(sh);
        end
        return acc;
    endfunction

    // x^254 is the inverse for x != 0 and maps 0 to 0, which is exactly what the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    logic [7:0] t;

    assign t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    assign y = gf_inv(t);
endmodule

module aes_inv_core #(
    parameter int NR = 14
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         hold_i,
    input  logic [127:0] ciphertext_i,
    output logic [3:0]   rk_idx_o,
    input  logic [127:0] rk_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [127:0] plaintext_o
);
    localparam logic [3:0] LAST_RK = 4'(NR);

    typedef enum logic [1:0] {IDLE, INIT, ROUND, FINAL} state_t;

    state_t       state;
    logic [3:0]   cnt;
    logic [127:0] s_q;
    logic [127:0] pt_q;
    logic         done_q;

    logic [127:0] sr;
    logic [127:0] sb;
    logic [127:0] ark;
    logic [127:0] imc;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant (9, 11, 13, 14) as a sum of b, 2b, 4b, 8b.
    function automatic logic [7:0] mulk(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] b2, b4, b8;
        b2 = xt(b);
        b4 = xt(b2);
        b8 = xt(b4);
        return (k[0] ? b : 8'h00) ^ (k[1] ? b2 : 8'h00) ^ (k[2] ? b4 : 8'h00) ^ (k[3] ? b8 : 8'h00);
    endfunction

    // Byte r+4c sits at bits [127-8(r+4c) -: 8]; row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] in);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = in[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] in);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = in[127 - 32*c -: 8];
            a1 = in[119 - 32*c -: 8];
            a2 = in[111 - 32*c -: 8];
            a3 = in[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = mulk(a0, 4'd14) ^ mulk(a1, 4'd11) ^ mulk(a2, 4'd13) ^ mulk(a3, 4'd9);
            o[119 - 32*c -: 8] = mulk(a0, 4'd9)  ^ mulk(a1, 4'd14) ^ mulk(a2, 4'd11) ^ mulk(a3, 4'd13);
            o[111 - 32*c -: 8] = mulk(a0, 4'd13) ^ mulk(a1, 4'd9)  ^ mulk(a2, 4'd14) ^ mulk(a3, 4'd11);
            o[103 - 32*c -: 8] = mulk(a0, 4'd11) ^ mulk(a1, 4'd13) ^ mulk(a2, 4'd9)  ^ mulk(a3, 4'd14);
        end
        return o;
    endfunction

    assign sr = inv_shift_rows(s_q);

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .a (sr[127 - 8*g -: 8]),
            .y (sb[127 - 8*g -: 8])
        );
    end

    assign ark = sb ^ rk_i;
    assign imc = inv_mix_columns(ark);

    // Round-key request follows the FSM: last key while idle/initialising, counter in rounds, key 0 at the end.
    always_comb begin
        rk_idx_o = LAST_RK;
        case (state)
            ROUND:   rk_idx_o = cnt;
            FINAL:   rk_idx_o = 4'd0;
            default: rk_idx_o = LAST_RK;
        endcase
    end

    assign busy_o      = (state != IDLE);
    assign done_o      = done_q;
    assign plaintext_o = pt_q;

    // Sequencer and datapath state: capture, initial key add, NR-1 full rounds, final round into plaintext.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            s_q    <= '0;
            pt_q   <= '0;
            done_q <= 1'b0;
        end else if (!hold_i) begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        s_q   <= ciphertext_i;
                        state <= INIT;
                    end
                end
                INIT: begin
                    s_q   <= s_q ^ rk_i;
                    cnt   <= LAST_RK - 4'd1;
                    state <= ROUND;
                end
                ROUND: begin
                    s_q <= imc;
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= FINAL;
                end
                FINAL: begin
                    pt_q   <= ark;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_inv_core.sv
module tb_aes_inv_core;
    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         start_i = 1'b0;
    logic         hold_i = 1'b0;
    logic [127:0] ciphertext_i = '0;
    logic [3:0]   rk_idx_o;
    logic [127:0] rk_i;
    logic         busy_o;
    logic         done_o;
    logic [127:0] plaintext_o;

    aes_inv_core #(.NR(14)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .hold_i       (hold_i),
        .ciphertext_i (ciphertext_i),
        .rk_idx_o     (rk_idx_o),
        .rk_i         (rk_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .plaintext_o  (plaintext_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference AES model ----------------
    logic [7:0]   sbox  [0:255];
    logic [7:0]   isbox [0:255];
    logic [127:0] rkeys [0:14];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = (b << n) | (b >> (8 - n));
        return r;
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic set_key(input logic [255:0] key);
        logic [31:0] w [0:59];
        logic [31:0] temp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            temp = w[i-1];
            if (i % 8 == 0) begin
                temp = subword({temp[23:0], temp[31:24]}) ^ {rc, 24'h000000};
                rc   = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                temp = subword(temp);
            end
            w[i] = w[i-8] ^ temp;
        end
        for (int r = 0; r < 15; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Textbook inverse cipher on a 16-byte array.
    function automatic logic [127:0] aes_dec(input logic [127:0] ct);
        logic [7:0]   st  [0:15];
        logic [7:0]   tmp [0:15];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] rk;
        logic [127:0] o;
        rk = rkeys[14];
        for (int i = 0; i < 16; i++) st[i] = ct[127 - 8*i -: 8] ^ rk[127 - 8*i -: 8];
        for (int r = 13; r >= 0; r--) begin
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    tmp[rr + 4*c] = isbox[st[rr + 4*((c - rr + 4) % 4)]];
            rk = rkeys[r];
            for (int i = 0; i < 16; i++) st[i] = tmp[i] ^ rk[127 - 8*i -: 8];
            if (r > 0) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
                    st[4*c+1] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
                    st[4*c+2] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
                    st[4*c+3] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
                end
            end
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = st[i];
        return o;
    endfunction

    // Round-key memory answering the DUT's index combinationally.
    always_comb begin
        rk_i = '0;
        if (rk_idx_o <= 4'd14) rk_i = rkeys[rk_idx_o];
    end

    // ---------------- timing model ----------------
    // m_left = edges still to go until the done edge; the key index counts down 14..0 alongside it.
    int           m_left = 0;
    bit           m_done = 1'b0;
    logic [127:0] m_pt   = '0;
    logic [127:0] m_exp  = '0;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_left = 0;
            m_done = 1'b0;
            m_pt   = '0;
        end else if (!hold_i) begin
            m_done = 1'b0;
            if (m_left != 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_pt   = m_exp;
                end
            end else if (start_i) begin
                m_left = 15;
                m_exp  = aes_dec(ciphertext_i);
            end
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("busy_o", 128'(busy_o), 128'(m_left != 0));
            check("done_o", 128'(done_o), 128'(m_done));
            check("rk_idx_o", 128'(rk_idx_o), 128'((m_left == 0) ? 14 : m_left - 1));
            check("plaintext_o", plaintext_o, m_pt);
        end
    end

    // ---------------- stimulus ----------------
    // Launch one block from a negedge with the DUT idle; returns the done edge (accept edge = 1).
    task automatic run_one(input logic [127:0] ct, input int hold_at, input int pulse_at, input bit rand_hold,
                           output int lat, output int ndone, output logic [127:0] pt);
        int edges = 0;
        int hold_left = 0;
        bit held = 1'b0;
        bit pulsed = 1'b0;
        int done_edge = -1;
        ndone = 0;
        pt = '0;
        start_i = 1'b1;
        ciphertext_i = ct;
        hold_i = 1'b0;
        while (edges < 200 && (done_edge < 0 || edges < done_edge + 4)) begin
            @(posedge clk_i);
            edges++;
            @(negedge clk_i);
            start_i = 1'b0;
            ciphertext_i = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (done_o) begin
                ndone++;
                if (done_edge < 0) begin
                    done_edge = edges;
                    pt = plaintext_o;
                end
            end
            if (rand_hold) begin
                hold_i = busy_o && ($urandom_range(0, 7) == 0);
            end else if (hold_left > 0) begin
                check("hold rk_idx_o", 128'(rk_idx_o), 128'(hold_at));
                check("hold busy_o", 128'(busy_o), 128'(1));
                hold_left--;
                hold_i = (hold_left > 0);
            end else if (hold_at >= 0 && !held && busy_o && rk_idx_o == 4'(hold_at)) begin
                hold_i = 1'b1;
                hold_left = 5;
                held = 1'b1;
            end
            if (pulse_at >= 0 && !pulsed && busy_o && rk_idx_o == 4'(pulse_at)) begin
                start_i = 1'b1;
                ciphertext_i = '0;
                pulsed = 1'b1;
            end
        end
        hold_i = 1'b0;
        start_i = 1'b0;
        if (done_edge < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_one timeout: no done_o within 200 edges, expected one");
        end
        lat = done_edge;
    endtask

    int           lat, nd, d1, d2, e;
    logic [127:0] pt, ct, expv;
    logic [255:0] key;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        build_tables();
        set_key(C3_KEY);

        // Pin the reference model itself against published values.
        check("model sbox[53]", 128'(sbox[8'h53]), 128'(8'hed));
        check("model isbox[00]", 128'(isbox[8'h00]), 128'(8'h52));
        check("model w[0]", rkeys[0], 128'h000102030405060708090a0b0c0d0e0f);
        check("model w[14]", rkeys[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
        check("model C.3 decrypt", aes_dec(C3_CT), C3_PT);

        // Reset state, checked between edges before any clock has arrived.
        #2 rst_i = 1'b1;
        #1;
        check("reset busy_o", 128'(busy_o), 128'(0));
        check("reset done_o", 128'(done_o), 128'(0));
        check("reset plaintext_o", plaintext_o, '0);
        check("reset rk_idx_o", 128'(rk_idx_o), 128'(14));
        chk_en = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        // C.3 vector, started on the first edge after reset release.
        run_one(C3_CT, -1, -1, 1'b0, lat, nd, pt);
        check("c3 latency", 128'(lat), 128'(16));
        check("c3 plaintext", pt, C3_PT);
        check("c3 done count", 128'(nd), 128'(1));

        // Hold for 5 cycles while the round counter is 7.
        run_one(C3_CT, 7, -1, 1'b0, lat, nd, pt);
        check("hold latency", 128'(lat), 128'(21));
        check("hold plaintext", pt, C3_PT);

        // start_i pulse with an all-zero block during round 10 must be ignored.
        run_one(C3_CT, -1, 10, 1'b0, lat, nd, pt);
        check("busy-start done count", 128'(nd), 128'(1));
        check("busy-start plaintext", pt, C3_PT);
        check("busy-start latency", 128'(lat), 128'(16));

        // Back-to-back: start_i held high across the first done cycle.
        start_i = 1'b1;
        ciphertext_i = C3_CT;
        d1 = -1;
        d2 = -1;
        e = 0;
        while (e < 100 && d2 < 0) begin
            @(posedge clk_i);
            e++;
            @(negedge clk_i);
            check("b2b busy vs done", 128'(busy_o), 128'(!done_o));
            if (done_o) begin
                if (d1 < 0) begin
                    d1 = e;
                    check("b2b plaintext 1", plaintext_o, C3_PT);
                end else begin
                    d2 = e;
                    check("b2b plaintext 2", plaintext_o, C3_PT);
                end
            end
            if (d1 >= 0 && e > d1) start_i = 1'b0;
        end
        start_i = 1'b0;
        check("b2b first latency", 128'(d1), 128'(16));
        check("b2b spacing", 128'(d2 - d1), 128'(16));

        // Reset asserted between edges while round 5 is in progress.
        @(negedge clk_i);
        start_i = 1'b1;
        ciphertext_i = C3_CT;
        e = 0;
        while (e < 40) begin
            @(posedge clk_i);
            e++;
            @(negedge clk_i);
            start_i = 1'b0;
            if (busy_o && rk_idx_o == 4'd5) break;
        end
        check("mid-reset reached round 5", 128'(rk_idx_o), 128'(5));
        #2 rst_i = 1'b1;
        #1;
        check("mid-reset busy_o", 128'(busy_o), 128'(0));
        check("mid-reset plaintext_o", plaintext_o, '0);
        check("mid-reset rk_idx_o", 128'(rk_idx_o), 128'(14));
        check("mid-reset done_o", 128'(done_o), 128'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        nd = 0;
        repeat (25) begin
            @(negedge clk_i);
            if (done_o) nd++;
        end
        check("mid-reset no done", 128'(nd), 128'(0));
        run_one(C3_CT, -1, -1, 1'b0, lat, nd, pt);
        check("post-reset plaintext", pt, C3_PT);
        check("post-reset latency", 128'(lat), 128'(16));

        // Random keys and blocks, with random holds while busy.
        for (int n = 0; n < 1000; n++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            set_key(key);
            ct = {$urandom(), $urandom(), $urandom(), $urandom()};
            expv = aes_dec(ct);
            run_one(ct, -1, -1, 1'b1, lat, nd, pt);
            check("random plaintext", pt, expv);
            check("random done count", 128'(nd), 128'(1));
        end

        @(negedge clk_i);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
